// File: rtl/ddr_rd_addr_arb_pkg.sv
// Shared types and helpers for the DDR read-address arbiter.
package ddr_rd_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_OUTS_DFLT = 4;

  // Counter width able to hold 0..max_outs inclusive.
  function automatic int unsigned outs_width(input int unsigned max_outs);
    return $clog2(max_outs + 1);
  endfunction

  localparam int unsigned OUTS_W = outs_width(MAX_OUTS_DFLT);

endpackage

// File: rtl/ddr_rd_addr_arb_rr_arb_core.sv
// Combinational round-robin priority encoder: searches upward from
// last_gnt+1 with wrap and returns the first requesting channel.
module rr_arb_core #(
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [IDX_W-1:0]  last_gnt,
  output logic [CH_NUM-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  // Rotate the search start past the previous winner and take the first hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= CH_NUM; off++) begin
      idx = IDX_W'((32'(last_gnt) + off) % CH_NUM);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_addr_arb.sv
// Read-address scheduler sharing one AXI AR port between CH_NUM channels,
// with per-channel outstanding-burst limits tracked by snooping R-last.
module ddr_rd_addr_arb
  import ddr_rd_arb_pkg::*;
#(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned ADDR_W   = 28,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        ch_vld,
  input  logic [CH_NUM*ADDR_W-1:0] ch_addr,
  input  logic [CH_NUM*LEN_W-1:0]  ch_len,
  output logic [CH_NUM-1:0]        ch_pop,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [LEN_W-1:0]         m_arlen,
  output logic [ID_W-1:0]          m_arid,
  input  logic                     m_rvalid,
  input  logic                     m_rready,
  input  logic                     m_rlast,
  input  logic [ID_W-1:0]          m_rid,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(CH_NUM);
  localparam int unsigned OW    = outs_width(MAX_OUTS);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [OW-1:0]     outs_q [CH_NUM];
  logic [OW-1:0]     outs_d [CH_NUM];

  logic [CH_NUM-1:0] elig;
  logic [CH_NUM-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              grant_fire;
  logic [CH_NUM-1:0] rlast_hit;
  logic              any_outs;

  // A channel may compete only with a valid head and headroom below the limit.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      elig[i] = ch_vld[i] && (outs_q[i] < OW'(MAX_OUTS));
    end
  end

  rr_arb_core #(
    .CH_NUM (CH_NUM),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req      (elig),
    .last_gnt (last_gnt_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .any      (gnt_any)
  );

  assign grant_fire = (state_q == ST_IDLE) && gnt_any;

  // Decode R-last completions per channel; IDs at or above CH_NUM match nothing.
  always_comb begin
    rlast_hit = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      rlast_hit[i] = m_rvalid && m_rready && m_rlast && (m_rid == ID_W'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: grant moves to ISSUE, AR handshake returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_any) state_d = ST_ISSUE;
      ST_ISSUE: if (m_arready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: pop is combinational in IDLE, AR valid is the ISSUE state.
  always_comb begin
    ch_pop    = (rst_n && grant_fire) ? gnt : '0;
    m_arvalid = (state_q == ST_ISSUE);
    busy      = (state_q == ST_ISSUE) || any_outs;
  end

  // Capture the granted head into the AR registers on the pop cycle.
  always_comb begin
    last_gnt_d = last_gnt_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arid_d     = arid_q;
    if (grant_fire) begin
      last_gnt_d = gnt_idx;
      araddr_d   = ch_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
      arlen_d    = ch_len[32'(gnt_idx)*LEN_W +: LEN_W];
      arid_d     = ID_W'(gnt_idx);
    end
  end

  // AR register bank; last_gnt starts at the top so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= IDX_W'(CH_NUM - 1);
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
    end
  end

  assign m_araddr = araddr_q;
  assign m_arlen  = arlen_q;
  assign m_arid   = arid_q;

  // Outstanding counters: +1 on grant, -1 on R-last, both cancel, floor at 0.
  always_comb begin
    any_outs = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      outs_d[i] = outs_q[i];
      if (ch_pop[i] && !rlast_hit[i]) begin
        outs_d[i] = outs_q[i] + OW'(1);
      end else if (!ch_pop[i] && rlast_hit[i] && (outs_q[i] != '0)) begin
        outs_d[i] = outs_q[i] - OW'(1);
      end
      any_outs = any_outs || (outs_q[i] != '0);
    end
  end

  // Counter array register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) outs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) outs_q[i] <= outs_d[i];
    end
  end

  // An R-last for a channel with nothing outstanding is a protocol error.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_underflow_chk
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(rlast_hit[g] && (outs_q[g] == '0)))
      else $error("R-last on channel %0d with no outstanding burst", g);
  end

endmodule

// File: tb/tb_ddr_rd_addr_arb.sv
// Scoreboard bench for ddr_rd_addr_arb: directed sequences push expected AR
// beats, an independent monitor checks every AR handshake against them.
module tb_ddr_rd_addr_arb;

  localparam int unsigned CH = 2;
  localparam int unsigned AW = 28;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CH-1:0]  ch_vld;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*LW-1:0] ch_len;
  logic [CH-1:0]  ch_pop;
  logic           m_arvalid, m_arready;
  logic [AW-1:0]  m_araddr;
  logic [LW-1:0]  m_arlen;
  logic [IW-1:0]  m_arid;
  logic           m_rvalid, m_rready, m_rlast;
  logic [IW-1:0]  m_rid;
  logic           busy;

  ddr_rd_addr_arb #(
    .CH_NUM   (CH),
    .ADDR_W   (AW),
    .LEN_W    (LW),
    .ID_W     (IW),
    .MAX_OUTS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_vld    (ch_vld),
    .ch_addr   (ch_addr),
    .ch_len    (ch_len),
    .ch_pop    (ch_pop),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arid    (m_arid),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rlast   (m_rlast),
    .m_rid     (m_rid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [IW-1:0] id;
  } ar_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] l;
  } req_t;

  ar_t  exp_q [$];
  req_t fifo [CH][$];

  int vectors    = 0;
  int miscompares = 0;

  logic [CH-1:0] s_pop;
  logic          s_arvalid, s_busy;
  logic [AW-1:0] s_araddr;
  logic [LW-1:0] s_arlen;
  logic [IW-1:0] s_arid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present each modelled FIFO head on the channel inputs.
  task automatic refresh();
    for (int c = 0; c < CH; c++) begin
      if (fifo[c].size() != 0) begin
        ch_vld[c]            = 1'b1;
        ch_addr[c*AW +: AW]  = fifo[c][0].a;
        ch_len[c*LW +: LW]   = fifo[c][0].l;
      end else begin
        ch_vld[c] = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_t r;
    r.a = a;
    r.l = l;
    fifo[c].push_back(r);
    refresh();
  endtask

  task automatic expect_ar(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] id);
    ar_t e;
    e.a  = a;
    e.l  = l;
    e.id = id;
    exp_q.push_back(e);
  endtask

  // One clock: sample outputs at negedge, then apply FIFO pops after posedge.
  task automatic cyc();
    @(negedge clk);
    s_pop     = ch_pop;
    s_arvalid = m_arvalid;
    s_araddr  = m_araddr;
    s_arlen   = m_arlen;
    s_arid    = m_arid;
    s_busy    = busy;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (s_pop[c] && fifo[c].size() != 0) void'(fifo[c].pop_front());
    end
    refresh();
  endtask

  task automatic rlast(input logic [IW-1:0] id);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rid    = id;
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rid    = '0;
  endtask

  // Monitor: pop invariants every cycle, AR hold stability, scoreboard on handshake.
  logic hold = 1'b0;
  ar_t  held;
  always @(negedge clk) begin
    ar_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      chk("pop_onehot", 32'($onehot0(ch_pop)), 32'd1);
      chk("pop_without_vld", 32'(ch_pop & ~ch_vld), 32'd0);
      if (hold) begin
        chk("ar_hold_valid", 32'(m_arvalid), 32'd1);
        chk("ar_hold_addr", 32'(m_araddr), 32'(held.a));
        chk("ar_hold_len", 32'(m_arlen), 32'(held.l));
        chk("ar_hold_id", 32'(m_arid), 32'(held.id));
      end
      if (m_arvalid && m_arready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ar: got addr 0x%0h id %0d, expected no AR", m_araddr, m_arid);
        end else begin
          e = exp_q.pop_front();
          chk("sb_araddr", 32'(m_araddr), 32'(e.a));
          chk("sb_arlen", 32'(m_arlen), 32'(e.l));
          chk("sb_arid", 32'(m_arid), 32'(e.id));
        end
      end
      hold    = m_arvalid && !m_arready;
      held.a  = m_araddr;
      held.l  = m_arlen;
      held.id = m_arid;
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [1:0] rr_pop [8];
    int cnt;

    rst_n     = 1'b0;
    ch_vld    = '0;
    ch_addr   = '0;
    ch_len    = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rready  = 1'b1;
    m_rlast   = 1'b0;
    m_rid     = '0;
    refresh();

    // Reset state
    repeat (3) cyc();
    chk("rst_arvalid", 32'(s_arvalid), 0);
    chk("rst_araddr", 32'(s_araddr), 0);
    chk("rst_arlen", 32'(s_arlen), 0);
    chk("rst_arid", 32'(s_arid), 0);
    chk("rst_pop", 32'(s_pop), 0);
    chk("rst_busy", 32'(s_busy), 0);
    rst_n = 1'b1;
    cyc();

    // Single request
    m_arready = 1'b1;
    push_req(0, 28'h100, 8'd15);
    expect_ar(28'h100, 8'd15, 4'd0);
    cyc();
    chk("t1_pop", 32'(s_pop), 32'b01);
    chk("t1_arvalid_c0", 32'(s_arvalid), 0);
    cyc();
    chk("t1_pop_c1", 32'(s_pop), 0);
    chk("t1_arvalid_c1", 32'(s_arvalid), 1);
    chk("t1_araddr", 32'(s_araddr), 32'h100);
    chk("t1_arlen", 32'(s_arlen), 15);
    chk("t1_arid", 32'(s_arid), 0);
    cyc();
    chk("t1_arvalid_c2", 32'(s_arvalid), 0);
    chk("t1_busy_outs", 32'(s_busy), 1);
    rlast(4'd0);
    cyc();
    chk("t1_busy_drained", 32'(s_busy), 0);

    // Round-robin: last winner was ch0, so ch1 leads
    push_req(0, 28'h1000, 8'd3);
    push_req(0, 28'h1040, 8'd3);
    push_req(1, 28'h2000, 8'd7);
    push_req(1, 28'h2080, 8'd7);
    expect_ar(28'h2000, 8'd7, 4'd1);
    expect_ar(28'h1000, 8'd3, 4'd0);
    expect_ar(28'h2080, 8'd7, 4'd1);
    expect_ar(28'h1040, 8'd3, 4'd0);
    rr_pop = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t2_rr_pop", 32'(s_pop), 32'(rr_pop[k]));
    end
    rlast(4'd0);
    rlast(4'd0);
    rlast(4'd1);
    rlast(4'd1);
    cyc();
    chk("t2_busy_drained", 32'(s_busy), 0);

    // Backpressure with a second channel waiting
    m_arready = 1'b0;
    push_req(0, 28'h3000, 8'd1);
    expect_ar(28'h3000, 8'd1, 4'd0);
    cyc();
    chk("t3_pop", 32'(s_pop), 32'b01);
    push_req(1, 28'h4000, 8'd2);
    expect_ar(28'h4000, 8'd2, 4'd1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t3_bp_pop", 32'(s_pop), 0);
      chk("t3_bp_arvalid", 32'(s_arvalid), 1);
      chk("t3_bp_araddr", 32'(s_araddr), 32'h3000);
      chk("t3_bp_arid", 32'(s_arid), 0);
    end
    m_arready = 1'b1;
    cyc();
    chk("t3_hs_arvalid", 32'(s_arvalid), 1);
    cyc();
    chk("t3_next_pop", 32'(s_pop), 32'b10);
    chk("t3_next_arvalid", 32'(s_arvalid), 0);
    cyc();
    chk("t3_ch1_araddr", 32'(s_araddr), 32'h4000);
    chk("t3_ch1_arid", 32'(s_arid), 1);
    rlast(4'd0);
    rlast(4'd1);

    // Outstanding limit on ch0
    for (int k = 0; k < 6; k++) push_req(0, 28'h5000 + 28'(k * 'h100), 8'(k));
    for (int k = 0; k < 4; k++) expect_ar(28'h5000 + 28'(k * 'h100), 8'(k), 4'd0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (s_pop[0]) cnt++;
    end
    chk("t4_grants_at_limit", 32'(cnt), 4);
    rlast(4'd3);
    chk("t4_rid3_cycle_pop", 32'(s_pop), 0);
    cyc();
    chk("t4_rid3_nopop_a", 32'(s_pop), 0);
    cyc();
    chk("t4_rid3_nopop_b", 32'(s_pop), 0);
    expect_ar(28'h5400, 8'd4, 4'd0);
    rlast(4'd0);
    chk("t4_rlast_cycle_pop", 32'(s_pop), 0);
    cyc();
    chk("t4_regrant_pop", 32'(s_pop), 32'b01);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (s_pop[0]) cnt++;
    end
    chk("t4_relimited", 32'(cnt), 0);

    // Simultaneous increment and decrement on ch1
    for (int k = 0; k < 6; k++) push_req(1, 28'h6000 + 28'(k * 'h40), 8'd0);
    for (int k = 0; k < 5; k++) expect_ar(28'h6000 + 28'(k * 'h40), 8'd0, 4'd1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t5_ramp_pop", 32'(s_pop), (k % 2 == 0) ? 32'b10 : 32'b00);
    end
    rlast(4'd1);
    chk("t5_incdec_pop", 32'(s_pop), 32'b10);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (s_pop[1]) cnt++;
    end
    chk("t5_grants_after_incdec", 32'(cnt), 1);

    // Reset while an AR is pending
    m_arready = 1'b0;
    rlast(4'd1);
    chk("t6_rlast_cycle_pop", 32'(s_pop), 0);
    cyc();
    chk("t6_pop", 32'(s_pop), 32'b10);
    cyc();
    chk("t6_arvalid", 32'(s_arvalid), 1);
    chk("t6_araddr", 32'(s_araddr), 32'h6140);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_arvalid", 32'(m_arvalid), 0);
    chk("t6_async_araddr", 32'(m_araddr), 0);
    chk("t6_async_arlen", 32'(m_arlen), 0);
    chk("t6_async_arid", 32'(m_arid), 0);
    chk("t6_async_pop", 32'(ch_pop), 0);
    chk("t6_async_busy", 32'(busy), 0);
    push_req(1, 28'h7000, 8'd9);
    cyc();
    cyc();
    rst_n     = 1'b1;
    m_arready = 1'b1;
    expect_ar(28'h5500, 8'd5, 4'd0);
    expect_ar(28'h7000, 8'd9, 4'd1);
    cyc();
    chk("t6_first_pop", 32'(s_pop), 32'b01);
    cyc();
    chk("t6_first_araddr", 32'(s_araddr), 32'h5500);
    chk("t6_first_arid", 32'(s_arid), 0);
    cyc();
    chk("t6_second_pop", 32'(s_pop), 32'b10);
    cyc();
    chk("t6_second_araddr", 32'(s_araddr), 32'h7000);
    chk("t6_second_arid", 32'(s_arid), 1);
    cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
